// File: rtl/sram_like_responder_if.sv
// SRAM-like req/addr_ok/data_ok bus between a requester (fetch/memory stage)
// and a responder. Handshake is req && addr_ok at the rising edge.
interface sram_like_responder_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_responder.sv
// In-order SRAM-like responder with a programmable latency floor and a
// word-addressed backing array. Define SRAM_RAND_STALL_EN for LFSR-driven stalls.
module sram_like_responder #(
    parameter int ADDR_WIDTH    = 14,
    parameter int DEPTH_LOG2    = 2,
    parameter int LATENCY       = 2,
    parameter     MEM_INIT_FILE = ""
) (
    input  logic                  clk,
    input  logic                  reset,
    sram_like_responder_if.slave  bus
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  cnt;
    } entry_t;

    entry_t                  q [DEPTH];
    logic [DEPTH-1:0]        vld;
    logic [DEPTH_LOG2-1:0]   head_ptr;
    logic [DEPTH_LOG2-1:0]   tail_ptr;
    logic [DEPTH_LOG2:0]     occ;
    logic [31:0]             mem [1 << ADDR_WIDTH];

    entry_t                  head;
    logic [ADDR_WIDTH-1:0]   head_idx;
    logic                    full;
    logic                    push;
    logic                    pop;
    logic                    go_acc;
    logic                    go_rsp;

`ifdef SRAM_RAND_STALL_EN
    logic [15:0] lfsr;

    // Fibonacci taps 16,14,13,11
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr <= 16'hACE1;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign go_acc = lfsr[0];
    assign go_rsp = lfsr[1];
`else
    assign go_acc = 1'b1;
    assign go_rsp = 1'b1;
`endif

    assign head     = q[head_ptr];
    assign head_idx = head.addr[ADDR_WIDTH+1:2];
    assign full     = (occ == (DEPTH_LOG2+1)'(DEPTH));

    // No bypass: a full queue refuses even when the head pops this cycle.
    assign bus.addr_ok = !reset && !full && go_acc;
    assign bus.data_ok = !reset && vld[head_ptr] && (head.cnt == 4'd0) && go_rsp;
    assign bus.rdata   = (bus.data_ok && !head.wr) ? mem[head_idx] : 32'h0;

    assign push = bus.req && bus.addr_ok;
    assign pop  = bus.data_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld      <= '0;
            head_ptr <= '0;
            tail_ptr <= '0;
            occ      <= '0;
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        end else begin
            // Countdown runs for every live entry, wherever it sits in the queue.
            for (int i = 0; i < DEPTH; i++)
                if (vld[i] && q[i].cnt != 4'd0) q[i].cnt <= q[i].cnt - 4'd1;
            if (pop) begin
                vld[head_ptr] <= 1'b0;
                head_ptr      <= head_ptr + 1'b1;
            end
            if (push) begin
                q[tail_ptr] <= '{wr: bus.wr, size: bus.size, wstrb: bus.wstrb,
                                 addr: bus.addr, wdata: bus.wdata, cnt: CNT_INIT};
                vld[tail_ptr] <= 1'b1;
                tail_ptr      <= tail_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Array has no reset so its contents survive a queue reset.
    always_ff @(posedge clk) begin
        if (pop && head.wr) begin
            for (int b = 0; b < 4; b++)
                if (head.wstrb[b]) mem[head_idx][8*b +: 8] <= head.wdata[8*b +: 8];
        end
    end

    // size is carried for the requester's benefit only; addr bits outside the index are ignored.
    logic unused_bits;
    assign unused_bits = ^{head.size, head.addr[31:ADDR_WIDTH+2], head.addr[1:0]};

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed bench for sram_like_responder: a LATENCY=2 instance for timing/data
// checks and a LATENCY=6 instance that can actually fill its queue.
module tb_sram_like_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        req, wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr, wdata;
    logic        aok, dok;
    logic [31:0] rd;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_like_responder_if ifa ();
    sram_like_responder_if ifb ();

    assign ifa.req = req && !sel;
    assign ifb.req = req && sel;
    assign ifa.wr = wr;       assign ifb.wr = wr;
    assign ifa.size = size;   assign ifb.size = size;
    assign ifa.wstrb = wstrb; assign ifb.wstrb = wstrb;
    assign ifa.addr = addr;   assign ifb.addr = addr;
    assign ifa.wdata = wdata; assign ifb.wdata = wdata;
    assign aok = sel ? ifb.addr_ok : ifa.addr_ok;
    assign dok = sel ? ifb.data_ok : ifa.data_ok;
    assign rd  = sel ? ifb.rdata   : ifa.rdata;

    sram_like_responder #(.ADDR_WIDTH(14), .DEPTH_LOG2(2), .LATENCY(2)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.slave));
    sram_like_responder #(.ADDR_WIDTH(14), .DEPTH_LOG2(2), .LATENCY(6)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        int t = 0;
        req = 1'b1; wr = w; addr = a; wdata = d; wstrb = s; size = 2'd2;
        while (!aok && t < 200) begin step(); t++; end
        if (!aok) chk("issue_timeout", 32'd0, 32'd1);
        step();
        req = 1'b0;
    endtask

    task automatic get_resp(output logic [31:0] d);
        int t = 0;
        while (!dok && t < 200) begin step(); t++; end
        if (!dok) begin
            chk("resp_timeout", 32'd0, 32'd1);
            d = 32'h0;
        end else begin
            d = rd;
            step();
        end
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        issue(1'b1, a, d, s);
        get_resp(r);
        chk("wr_rdata_zero", r, 32'h0);
    endtask

    task automatic read_word(input logic [31:0] a, output logic [31:0] d);
        issue(1'b0, a, 32'h0, 4'h0);
        get_resp(d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] model [16];
        logic [31:0] q_d [$];
        int          q_c [$];
        int          n_iss, n_rsp, guard, w, c_now, ec, nd;
        logic        have, acc;
        logic [31:0] ed;

        reset = 1'b1; sel = 1'b0; req = 1'b0; wr = 1'b0; size = 2'd2;
        wstrb = 4'h0; addr = 32'h0; wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_addr_ok", {31'd0, aok}, 32'd0);
        chk("rst_data_ok", {31'd0, dok}, 32'd0);
        chk("rst_rdata", rd, 32'h0);
        #2 reset = 1'b0;
        step();

`ifndef SRAM_RAND_STALL_EN
        chk("post_rst_addr_ok", {31'd0, aok}, 32'd1);

        // Single read: data_ok exactly LATENCY edges after the accept edge.
        write_word(32'h100, 32'hDEADBEEF, 4'hF);
        req = 1'b1; wr = 1'b0; addr = 32'h100;
        chk("t1_addr_ok", {31'd0, aok}, 32'd1);
        step();
        req = 1'b0;
        chk("t1_dok_e1", {31'd0, dok}, 32'd0);
        step();
        chk("t1_dok_e2", {31'd0, dok}, 32'd1);
        chk("t1_rdata", rd, 32'hDEADBEEF);
        step();
        chk("t1_dok_e3", {31'd0, dok}, 32'd0);

        // Partial write merges only the enabled byte lanes.
        write_word(32'h20, 32'hAABBCCDD, 4'hF);
        write_word(32'h20, 32'h11223344, 4'b0011);
        read_word(32'h20, r);
        chk("t3_merge", r, 32'hAABB3344);

        // Fill on the slow instance, then pop while full.
        sel = 1'b1;
        for (int i = 0; i < 5; i++) write_word(32'(i * 4), 32'hA0 + 32'(i), 4'hF);
        for (int c = 0; c < 11; c++) begin
            req  = (c < 8);
            wr   = 1'b0;
            addr = (c < 4) ? 32'(c * 4) : 32'h10;
            chk($sformatf("fill_aok_c%0d", c), {31'd0, aok}, {31'd0, (c < 4 || c > 6)});
            chk($sformatf("fill_dok_c%0d", c), {31'd0, dok}, {31'd0, (c >= 6 && c <= 9)});
            chk($sformatf("fill_rd_c%0d", c), rd,
                (c >= 6 && c <= 9) ? 32'hA0 + 32'(c - 6) : 32'h0);
            step();
        end
        req = 1'b0;
        get_resp(r);
        chk("fill_last", r, 32'hA4);

        // Ten pipelined reads wrap both pointers.
        n_iss = 0; n_rsp = 0; guard = 0;
        while (n_rsp < 10 && guard < 400) begin
            req  = (n_iss < 10);
            addr = 32'((n_iss % 5) * 4);
            acc  = req && aok;
            if (dok) begin
                chk($sformatf("wrap_rd%0d", n_rsp), rd, 32'hA0 + 32'(n_rsp % 5));
                n_rsp++;
            end
            step();
            if (acc) n_iss++;
            guard++;
        end
        req = 1'b0;
        chk("wrap_count", 32'(n_rsp), 32'd10);

        // Async reset with requests in flight.
        sel = 1'b0;
        req = 1'b1; wr = 1'b0; addr = 32'h100;
        step();
        addr = 32'h20;
        step();
        addr = 32'h100;
        step();
        req = 1'b0;
        chk("rst_pre_dok", {31'd0, dok}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_aok", {31'd0, aok}, 32'd0);
        chk("arst_dok", {31'd0, dok}, 32'd0);
        chk("arst_rd", rd, 32'h0);
        @(posedge clk);
        #3 reset = 1'b0;
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (dok) nd++;
        end
        chk("arst_no_stale", 32'(nd), 32'd0);
        chk("arst_aok_after", {31'd0, aok}, 32'd1);
        read_word(32'h100, r);
        chk("arst_mem0", r, 32'hDEADBEEF);
        read_word(32'h20, r);
        chk("arst_mem1", r, 32'hAABB3344);
`endif

        // Random mix against a byte-lane scoreboard; timing-agnostic.
        sel = 1'b0;
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            write_word(32'h200 + 32'(i * 4), model[i], 4'hF);
        end
        n_iss = 0; n_rsp = 0; guard = 0; have = 1'b0; w = 0;
        while (n_rsp < 200 && guard < 20000) begin
            if (n_iss < 200 && !have) begin
                wr    = 1'($urandom_range(0, 1));
                w     = int'($urandom_range(0, 15));
                addr  = 32'h200 + 32'(w * 4) + 32'($urandom_range(0, 3))
                        + (32'($urandom_range(0, 1)) << 16);
                wdata = $urandom;
                wstrb = 4'($urandom_range(0, 15));
                have  = 1'b1;
            end
            req   = have;
            acc   = have && aok;
            c_now = cyc;
            if (dok) begin
                if (q_d.size() == 0) begin
                    chk("rnd_spurious", 32'd1, 32'd0);
                end else begin
                    ed = q_d.pop_front();
                    ec = q_c.pop_front();
                    chk("rnd_data", rd, ed);
                    chk("rnd_latency", {31'd0, (c_now - ec) >= 2}, 32'd1);
                end
                n_rsp++;
            end
            step();
            if (acc) begin
                if (wr) begin
                    for (int b = 0; b < 4; b++)
                        if (wstrb[b]) model[w][8*b +: 8] = wdata[8*b +: 8];
                    q_d.push_back(32'h0);
                end else begin
                    q_d.push_back(model[w]);
                end
                q_c.push_back(c_now);
                n_iss++;
                have = 1'b0;
            end
            guard++;
        end
        req = 1'b0;
        chk("rnd_count", 32'(n_rsp), 32'd200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
